// File: rtl/traffic_phase_ctrl.sv
// Traffic-light phase sequencer: GREEN -> YELLOW -> RED on seconds ticks,
// with pedestrian-shortened GREEN and a service FLASH phase while hold is high.
module traffic_phase_ctrl #(
  parameter int GREEN_T  = 15,
  parameter int YELLOW_T = 5,
  parameter int RED_T    = 10,
  parameter int PED_MIN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       hold,
  output logic [1:0] state,
  output logic [3:0] count,
  output logic       phase_start,
  output logic       ped_ack
);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    FLASH  = 2'd3
  } phase_e;

  localparam logic [3:0] G_CNT   = 4'(GREEN_T);
  localparam logic [3:0] Y_CNT   = 4'(YELLOW_T);
  localparam logic [3:0] R_CNT   = 4'(RED_T);
  localparam logic [3:0] PED_CNT = 4'(PED_MIN);

  phase_e     phase_q, phase_d;
  logic [3:0] count_q, count_d;
  logic       ps_q, ps_d;
  logic       ack_q, ack_d;
  logic       pend_q, pend_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= RED;
      count_q <= R_CNT;
      ps_q    <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
      ps_q    <= ps_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    count_d = count_q;
    ps_d    = 1'b0;
    ack_d   = 1'b0;
    pend_d  = pend_q;
    if (hold) begin
      // the pulse marks FLASH entry only; a tick in this cycle is dropped
      phase_d = FLASH;
      count_d = 4'd0;
      pend_d  = 1'b0;
      ps_d    = (phase_q != FLASH);
    end else if (phase_q == FLASH) begin
      phase_d = RED;
      count_d = R_CNT;
      ps_d    = 1'b1;
    end else begin
      if (ped_req && (phase_q == GREEN || phase_q == YELLOW))
        pend_d = 1'b1;
      if (tick) begin
        if (count_q == 4'd1) begin
          ps_d = 1'b1;
          unique case (phase_q)
            GREEN:  begin phase_d = YELLOW; count_d = Y_CNT; end
            YELLOW: begin
              // a request arriving in the RED-entry cycle is discarded
              phase_d = RED;
              count_d = R_CNT;
              ack_d   = pend_q;
              pend_d  = 1'b0;
            end
            default: begin phase_d = GREEN; count_d = G_CNT; end
          endcase
        end else if (phase_q == GREEN && pend_q && count_q > PED_CNT) begin
          count_d = PED_CNT;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
    end
  end

  assign state       = phase_q;
  assign count       = count_q;
  assign phase_start = ps_q;
  assign ped_ack     = ack_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: a reference model queues the expected
// outputs per driven cycle; they are popped and compared after the edge.
module tb_traffic_phase_ctrl;

  localparam int GT = 15, YT = 5, RT = 10, PM = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] state;
  logic [3:0] count;
  logic       phase_start;
  logic       ped_ack;

  traffic_phase_ctrl #(.GREEN_T(GT), .YELLOW_T(YT), .RED_T(RT), .PED_MIN(PM)) dut (
    .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req), .hold(hold),
    .state(state), .count(count), .phase_start(phase_start), .ped_ack(ped_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int cnt;
    int ps;
    int ack;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // reference model state
  int  m_st = 2;
  int  m_cnt = RT;
  bit  m_pend = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit tk, input bit pr, input bit hd, output exp_t e);
    bit was;
    e.ps = 0;
    e.ack = 0;
    if (!rst) begin
      m_st = 2; m_cnt = RT; m_pend = 1'b0;
    end else if (hd) begin
      e.ps = (m_st != 3) ? 1 : 0;
      m_st = 3; m_cnt = 0; m_pend = 1'b0;
    end else if (m_st == 3) begin
      m_st = 2; m_cnt = RT; e.ps = 1;
    end else begin
      was = m_pend;
      if (pr && (m_st == 0 || m_st == 1)) m_pend = 1'b1;
      if (tk) begin
        if (m_cnt == 1) begin
          e.ps = 1;
          if (m_st == 0)      begin m_st = 1; m_cnt = YT; end
          else if (m_st == 1) begin m_st = 2; m_cnt = RT; e.ack = was ? 1 : 0; m_pend = 1'b0; end
          else                begin m_st = 0; m_cnt = GT; end
        end else if (m_st == 0 && was && m_cnt > PM) begin
          m_cnt = PM;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
    e.st = m_st;
    e.cnt = m_cnt;
  endtask

  // drive one cycle, queue its expectation, then compare after the edge
  task automatic step(input bit rst, input bit tk, input bit pr, input bit hd);
    exp_t e;
    reset = rst; tick = tk; ped_req = pr; hold = hd;
    model(rst, tk, pr, hd, e);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("state", int'(state), e.st);
    chk("count", int'(count), e.cnt);
    chk("phase_start", int'(phase_start), e.ps);
    chk("ped_ack", int'(ped_ack), e.ack);
  endtask

  task automatic ticks(input int n, input bit pr);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, pr, 1'b0);
  endtask

  task automatic expect_now(input string tag, input int st, input int cnt, input int ps, input int ack);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".count"}, int'(count), cnt);
    chk({tag, ".phase_start"}, int'(phase_start), ps);
    chk({tag, ".ped_ack"}, int'(ped_ack), ack);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    expect_now("reset", 2, RT, 0, 0);

    // basic cycle
    ticks(9, 1'b0);
    expect_now("red_last", 2, 1, 0, 0);
    ticks(1, 1'b0);
    expect_now("green_entry", 0, 15, 1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_now("green_idle", 0, 15, 0, 0);
    ticks(15, 1'b0);
    expect_now("yellow_entry", 1, 5, 1, 0);
    ticks(5, 1'b0);
    expect_now("red_entry", 2, 10, 1, 0);

    // pedestrian cut
    ticks(10, 1'b0);
    ticks(3, 1'b0);
    expect_now("green12", 0, 12, 0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    ticks(1, 1'b0);
    expect_now("ped_cut", 0, 3, 0, 0);
    ticks(3, 1'b0);
    expect_now("cut_yellow", 1, 5, 1, 0);
    ticks(5, 1'b0);
    expect_now("ped_ack", 2, 10, 1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_now("ack_once", 2, 10, 0, 0);

    // late request: no cut, still served
    ticks(10, 1'b0);
    ticks(13, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    ticks(1, 1'b0);
    expect_now("no_cut", 0, 1, 0, 0);
    ticks(1, 1'b0);
    expect_now("late_yellow", 1, 5, 1, 0);
    ticks(5, 1'b0);
    expect_now("late_ack", 2, 10, 1, 1);

    // requests in RED ignored
    ticks(10, 1'b1);
    expect_now("red_ign_green", 0, 15, 1, 0);
    ticks(14, 1'b0);
    expect_now("full_green", 0, 1, 0, 0);
    ticks(6, 1'b0);
    expect_now("no_ack", 2, 10, 1, 0);

    // service mode
    ticks(10, 1'b0);
    ticks(15, 1'b0);
    ticks(2, 1'b0);
    expect_now("yellow3", 1, 3, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    expect_now("flash_entry", 3, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    expect_now("flash_stay", 3, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_now("flash_exit", 2, 10, 1, 0);

    // mid-operation reset drops a pending request
    ticks(10, 1'b0);
    ticks(8, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    expect_now("green7", 0, 7, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("mid_reset", 2, 10, 0, 0);
    ticks(10, 1'b0);
    ticks(15, 1'b0);
    ticks(5, 1'b0);
    expect_now("reset_no_ack", 2, 10, 1, 0);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
